// File: rtl/mux_nne1_rr_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux_nne1_rr_if
//  Description : Bundle of producer-side and consumer-side handshake signals
//                for the N-to-1 registered multiplexer mux_nne1_rr.
//                  a           N*W  packed producer words, channel i = a[i*W +: W]
//                  a_valid     N    channel i offers a word
//                  a_ready     N    channel i word taken this cycle (one-hot/zero)
//                  s           SW   fixed source select (mode 0)
//                  mode        1    0 = fixed select, 1 = round-robin
//                  dalja       W    registered output word
//                  dalja_valid 1    dalja holds a word
//                  dalja_ready 1    consumer takes dalja this cycle
//                  grant       SW   source index of the word held in dalja
//                The "slave" modport is the multiplexer itself; the "master"
//                modport is the surrounding producers plus the consumer.
//  Revision    : 1.0  initial release
// ============================================================================
interface mux_nne1_rr_if #(
    parameter int W = 16,
    parameter int N = 4
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic [N*W-1:0] a;
    logic [N-1:0]   a_valid;
    logic [N-1:0]   a_ready;
    logic [SW-1:0]  s;
    logic           mode;
    logic [W-1:0]   dalja;
    logic           dalja_valid;
    logic           dalja_ready;
    logic [SW-1:0]  grant;

    modport slave (
        input  a,
        input  a_valid,
        input  s,
        input  mode,
        input  dalja_ready,
        output a_ready,
        output dalja,
        output dalja_valid,
        output grant
    );

    modport master (
        output a,
        output a_valid,
        output s,
        output mode,
        output dalja_ready,
        input  a_ready,
        input  dalja,
        input  dalja_valid,
        input  grant
    );
endinterface
`default_nettype wire

// File: rtl/mux_nne1_rr.sv
`default_nettype none
// ============================================================================
//  Module      : mux_nne1_rr
//  Description : Parametrised N-to-1 datapath multiplexer with a registered
//                output and valid/ready handshakes on both sides.
//                Mode 0 selects channel s; mode 1 arbitrates round-robin
//                among the requesting channels, starting after the channel
//                granted last.
//  Ports       : clk   in   rising-edge clock
//                rst   in   asynchronous active-high reset
//                bus   slave modport of mux_nne1_rr_if (data, handshakes,
//                      select, mode, grant)
//  Revision    : 1.0  initial release
// ============================================================================
module mux_nne1_rr #(
    parameter int W = 16,
    parameter int N = 4
) (
    input  wire logic    clk,
    input  wire logic    rst,
    mux_nne1_rr_if.slave bus
);

    localparam int SW = (N > 1) ? $clog2(N) : 1;

    // Output register occupancy
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]    state_q, state_d;
    logic [W-1:0]  dalja_q, dalja_d;
    logic [SW-1:0] grant_q, grant_d;
    logic [SW-1:0] ptr_q,   ptr_d;

    // ------------------------------------------------------------------------
    // Source selection
    // ------------------------------------------------------------------------
    logic          fix_hit;
    logic          rr_hit;
    logic [SW-1:0] rr_sel;
    logic          hit;
    logic [SW-1:0] sel;
    logic [W-1:0]  sel_word;
    logic          load;
    logic          xfer;
    logic [N-1:0]  a_ready_w;

    // Fixed select: compare s against each real channel index so that an
    // out-of-range s (possible when N is not a power of two) never hits.
    always_comb begin
        fix_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (bus.s == SW'(i)) begin
                fix_hit = bus.a_valid[i];
            end
        end
    end

    // Round-robin: first pass looks above the pointer, second pass wraps to
    // the channels at or below it, so the last winner has lowest priority.
    always_comb begin
        rr_hit = 1'b0;
        rr_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (!rr_hit && bus.a_valid[i] && (SW'(i) > ptr_q)) begin
                rr_hit = 1'b1;
                rr_sel = SW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!rr_hit && bus.a_valid[i] && (SW'(i) <= ptr_q)) begin
                rr_hit = 1'b1;
                rr_sel = SW'(i);
            end
        end
    end

    always_comb begin
        hit = bus.mode ? rr_hit : fix_hit;
        sel = bus.mode ? rr_sel : bus.s;
    end

    // Data selection by index loop keeps the part-select in range for any s.
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SW'(i)) begin
                sel_word = bus.a[i*W +: W];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    // The register can accept when empty or when being drained this cycle.
    // Nothing is acknowledged while reset is asserted, since the register
    // would discard it.
    always_comb begin
        load = (state_q == ST_EMPTY) || bus.dalja_ready;
        xfer = load && hit && !rst;
    end

    always_comb begin
        a_ready_w = '0;
        for (int i = 0; i < N; i++) begin
            a_ready_w[i] = xfer && (sel == SW'(i));
        end
    end

    // ------------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        dalja_d = dalja_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        if (load) begin
            if (hit) begin
                state_d = ST_FULL;
                dalja_d = sel_word;
                grant_d = sel;
                if (bus.mode) begin
                    ptr_d = sel;
                end
            end else begin
                // Drained with nothing to refill: word and grant keep their
                // last values, only occupancy drops.
                state_d = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            dalja_q <= '0;
            grant_q <= '0;
            ptr_q   <= SW'(N - 1);   // channel 0 wins the first arbitration
        end else begin
            state_q <= state_d;
            dalja_q <= dalja_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.a_ready     = a_ready_w;
    assign bus.dalja       = dalja_q;
    assign bus.dalja_valid = (state_q == ST_FULL);
    assign bus.grant       = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_nne1_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_nne1_rr
//  Description : Directed self-checking bench for mux_nne1_rr, with a 4-input
//                and a 3-input instance sharing clock and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mux_nne1_rr;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mux_nne1_rr_if #(.W(16), .N(4)) bus4 ();
    mux_nne1_rr_if #(.W(16), .N(3)) bus3 ();

    mux_nne1_rr #(.W(16), .N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    mux_nne1_rr #(.W(16), .N(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] w4 [4];
    logic [1:0]  exp_g [6];

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus4.a = '0; bus4.a_valid = '0; bus4.s = '0; bus4.mode = 1'b0; bus4.dalja_ready = 1'b0;
        bus3.a = '0; bus3.a_valid = '0; bus3.s = '0; bus3.mode = 1'b0; bus3.dalja_ready = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_dalja",   32'(bus4.dalja),       32'h0);
        chk("rst_valid",   32'(bus4.dalja_valid), 32'h0);
        chk("rst_grant",   32'(bus4.grant),       32'h0);
        chk("rst_a_ready", 32'(bus4.a_ready),     32'h0);
        rst = 1'b0;

        // ---------------- 1: mode 0, s=2 ----------------
        w4[0] = 16'hA000; w4[1] = 16'hA111; w4[2] = 16'hBEEF; w4[3] = 16'hA333;
        bus4.a = {w4[3], w4[2], w4[1], w4[0]};
        bus4.mode = 1'b0; bus4.s = 2'd2; bus4.a_valid = 4'b0100; bus4.dalja_ready = 1'b1;
        #1;
        chk("m0_a_ready", 32'(bus4.a_ready), 32'h4);
        step();
        chk("m0_dalja", 32'(bus4.dalja),       32'hBEEF);
        chk("m0_valid", 32'(bus4.dalja_valid), 32'h1);
        chk("m0_grant", 32'(bus4.grant),       32'h2);
        // drain with no refill: goes empty, word and grant held
        bus4.a_valid = 4'b0000;
        step();
        chk("drain_valid", 32'(bus4.dalja_valid), 32'h0);
        chk("drain_dalja", 32'(bus4.dalja),       32'hBEEF);
        chk("drain_grant", 32'(bus4.grant),       32'h2);

        // ---------------- 2: mode 1, all valid ----------------
        // pointer still at reset value 3 (mode 0 did not move it)
        exp_g[0] = 2'd0; exp_g[1] = 2'd1; exp_g[2] = 2'd2;
        exp_g[3] = 2'd3; exp_g[4] = 2'd0; exp_g[5] = 2'd1;
        bus4.mode = 1'b1; bus4.a_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr4_a_ready", 32'(bus4.a_ready), 32'(4'b0001 << exp_g[k]));
            step();
            chk("rr4_grant", 32'(bus4.grant),       32'(exp_g[k]));
            chk("rr4_dalja", 32'(bus4.dalja),       32'(w4[exp_g[k]]));
            chk("rr4_valid", 32'(bus4.dalja_valid), 32'h1);
        end

        // ---------------- 3: mode 1, a_valid=1010 ----------------
        // pointer at 1 -> 3, 1, 3, 1
        bus4.a_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr2_grant", 32'(bus4.grant), (k % 2 == 0) ? 32'h3 : 32'h1);
        end

        // ---------------- 4: stall ----------------
        w4[0] = 16'h1234;
        bus4.a = {w4[3], w4[2], w4[1], w4[0]};
        bus4.a_valid = 4'b0001;
        step();
        chk("st_load_dalja", 32'(bus4.dalja), 32'h1234);
        chk("st_load_grant", 32'(bus4.grant), 32'h0);
        bus4.dalja_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus4.a       = {16'h5550 + 16'(k), 16'h6660, 16'h7770 + 16'(k), 16'h8880};
            bus4.a_valid = 4'b1111;
            bus4.mode    = k[0];
            bus4.s       = 2'(k);
            #1;
            chk("st_a_ready", 32'(bus4.a_ready), 32'h0);
            step();
            chk("st_dalja", 32'(bus4.dalja),       32'h1234);
            chk("st_valid", 32'(bus4.dalja_valid), 32'h1);
            chk("st_grant", 32'(bus4.grant),       32'h0);
        end
        // release: pointer at 0, so channel 1 loads with no bubble
        bus4.mode = 1'b1;
        bus4.a    = {16'hD333, 16'hD222, 16'hD111, 16'hD000};
        bus4.dalja_ready = 1'b1;
        #1;
        chk("rel_a_ready", 32'(bus4.a_ready), 32'h2);
        step();
        chk("rel_dalja", 32'(bus4.dalja),       32'hD111);
        chk("rel_valid", 32'(bus4.dalja_valid), 32'h1);
        chk("rel_grant", 32'(bus4.grant),       32'h1);

        // ---------------- 5: async reset mid-stall ----------------
        bus4.dalja_ready = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("ar_dalja", 32'(bus4.dalja),       32'h0);
        chk("ar_valid", 32'(bus4.dalja_valid), 32'h0);
        chk("ar_grant", 32'(bus4.grant),       32'h0);
        bus4.dalja_ready = 1'b1;
        #1;
        chk("ar_a_ready", 32'(bus4.a_ready), 32'h0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_a_ready", 32'(bus4.a_ready), 32'h1);
        step();
        chk("post_rst_grant", 32'(bus4.grant), 32'h0);
        chk("post_rst_dalja", 32'(bus4.dalja), 32'hD000);
        bus4.a_valid = 4'b0000;

        // ---------------- 6: N=3, out-of-range select ----------------
        bus3.a    = {16'hC222, 16'hC111, 16'hC000};
        bus3.mode = 1'b0; bus3.s = 2'd3; bus3.a_valid = 3'b111; bus3.dalja_ready = 1'b1;
        #1;
        chk("n3_oor_a_ready", 32'(bus3.a_ready), 32'h0);
        step();
        chk("n3_oor_valid", 32'(bus3.dalja_valid), 32'h0);
        bus3.s = 2'd1;
        #1;
        chk("n3_s1_a_ready", 32'(bus3.a_ready), 32'h2);
        step();
        chk("n3_s1_grant", 32'(bus3.grant),       32'h1);
        chk("n3_s1_dalja", 32'(bus3.dalja),       32'hC111);
        chk("n3_s1_valid", 32'(bus3.dalja_valid), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
